// File: rtl/rst_watchdog_pkg.sv
// -----------------------------------------------------------------------------
// rst_watchdog_pkg
// Shared types and constants for the reset-request watchdog.
//   wd_state_e     : 2-bit FSM state encoding (DISABLED, RUN, WARN, FIRE).
//   WD_KEY_DEFAULT : default value a kick must carry to be accepted.
// -----------------------------------------------------------------------------
package rst_watchdog_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_WARN     = 2'd2,
        ST_FIRE     = 2'd3
    } wd_state_e;

    localparam logic [7:0] WD_KEY_DEFAULT = 8'hA5;

endpackage : rst_watchdog_pkg

// File: rtl/rst_watchdog.sv
// -----------------------------------------------------------------------------
// rst_watchdog
// Keyed watchdog timer that produces an active-low reset request. Software
// loads a timeout and enables the block, then must kick it with the correct
// key before the count runs out. On expiry or on a kick with a wrong key the
// block pulls RST_REQ_X low for HOLD_CYC cycles, latches TIMEOUT_SEEN and
// rearms itself with the last loaded timeout.
//
// RST_X must be driven from the power-on reset path, not from the system
// reset this block requests, otherwise TIMEOUT_SEEN would be wiped by the
// very reset it is meant to record.
//
// Ports
//   CLK          in   system clock
//   RST_X        in   synchronous active-low reset
//   CFG_WE       in   config write strobe
//   CFG_EN       in   enable bit, sampled with CFG_WE
//   CFG_TIMEOUT  in   timeout value T, sampled with CFG_WE
//   KICK         in   kick strobe
//   KICK_KEY     in   kick key, sampled with KICK
//   CLR_FLAG     in   clears TIMEOUT_SEEN
//   RST_REQ_X    out  registered active-low reset request
//   WARN         out  registered, high while in the WARN state
//   TIMEOUT_SEEN out  sticky flag, set on every fire
//   CNT_O        out  current count
// -----------------------------------------------------------------------------
module rst_watchdog
    import rst_watchdog_pkg::*;
#(
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned HOLD_CYC = 16,
    parameter logic [7:0]  KEY      = WD_KEY_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             CFG_WE,
    input  logic             CFG_EN,
    input  logic [CNT_W-1:0] CFG_TIMEOUT,
    input  logic             KICK,
    input  logic [7:0]       KICK_KEY,
    input  logic             CLR_FLAG,
    output logic             RST_REQ_X,
    output logic             WARN,
    output logic             TIMEOUT_SEEN,
    output logic [CNT_W-1:0] CNT_O
);

    // The hold counter only has to reach HOLD_CYC-1.
    localparam int unsigned       HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    wd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  load_q, load_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rst_req_x_q, rst_req_x_d;
    logic              warn_q, warn_d;
    logic              seen_q, seen_d;

    logic              cfg_zero_s;
    logic              cfg_arm_s;
    logic              cfg_disarm_s;
    logic              kick_good_s;
    logic              kick_bad_s;
    logic [CNT_W-1:0]  cnt_dec_s;
    logic [CNT_W-1:0]  warn_lvl_s;
    logic              fire_entry_s;

    // Decode of the config and kick strobes plus counter arithmetic.
    always_comb begin
        cfg_zero_s   = (CFG_TIMEOUT == CNT_ZERO);
        // An enable write with T=0 is handled exactly like a disable write.
        cfg_arm_s    = CFG_WE & CFG_EN & ~cfg_zero_s;
        cfg_disarm_s = CFG_WE & (~CFG_EN | cfg_zero_s);
        kick_good_s  = KICK & (KICK_KEY == KEY);
        kick_bad_s   = KICK & (KICK_KEY != KEY);
        cnt_dec_s    = cnt_q - CNT_ONE;
        warn_lvl_s   = load_q >> 1;
    end

    // Next-state, counter, hold stretcher and output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_d       = load_q;
        hold_d       = hold_q;
        rst_req_x_d  = rst_req_x_q;
        warn_d       = warn_q;
        seen_d       = seen_q;
        fire_entry_s = 1'b0;

        case (state_q)
            ST_DISABLED: begin
                rst_req_x_d = 1'b1;
                warn_d      = 1'b0;
                if (cfg_arm_s) begin
                    load_d  = CFG_TIMEOUT;
                    cnt_d   = CFG_TIMEOUT;
                    state_d = ST_RUN;
                end else begin
                    // Count is pinned at zero; kicks and disables change nothing.
                    cnt_d   = CNT_ZERO;
                    state_d = ST_DISABLED;
                end
            end

            ST_RUN, ST_WARN: begin
                rst_req_x_d = 1'b1;
                if (cfg_disarm_s) begin
                    cnt_d   = CNT_ZERO;
                    warn_d  = 1'b0;
                    state_d = ST_DISABLED;
                end else if (cfg_arm_s) begin
                    load_d  = CFG_TIMEOUT;
                    cnt_d   = CFG_TIMEOUT;
                    warn_d  = 1'b0;
                    state_d = ST_RUN;
                end else if (kick_bad_s) begin
                    fire_entry_s = 1'b1;
                end else if (kick_good_s) begin
                    // Checked before expiry, so a kick at cnt==0 still rescues.
                    cnt_d   = load_q;
                    warn_d  = 1'b0;
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_ZERO) begin
                    fire_entry_s = 1'b1;
                end else begin
                    cnt_d = cnt_dec_s;
                    if (cnt_dec_s <= warn_lvl_s) begin
                        warn_d  = 1'b1;
                        state_d = ST_WARN;
                    end else begin
                        warn_d  = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_FIRE: begin
                // Config writes and kicks are deliberately not looked at here.
                warn_d = 1'b0;
                if (hold_q == HOLD_ZERO) begin
                    rst_req_x_d = 1'b1;
                    cnt_d       = load_q;
                    state_d     = ST_RUN;
                end else begin
                    rst_req_x_d = 1'b0;
                    hold_d      = hold_q - HOLD_ONE;
                    state_d     = ST_FIRE;
                end
            end

            default: begin
                state_d     = ST_DISABLED;
                cnt_d       = CNT_ZERO;
                hold_d      = HOLD_ZERO;
                rst_req_x_d = 1'b1;
                warn_d      = 1'b0;
            end
        endcase

        if (fire_entry_s) begin
            state_d     = ST_FIRE;
            rst_req_x_d = 1'b0;
            hold_d      = HOLD_INIT;
            warn_d      = 1'b0;
        end else begin
            state_d     = state_d;
        end

        // A fire on the same cycle as a clear request leaves the flag set.
        if (fire_entry_s) begin
            seen_d = 1'b1;
        end else if (CLR_FLAG) begin
            seen_d = 1'b0;
        end else begin
            seen_d = seen_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q     <= ST_DISABLED;
            cnt_q       <= CNT_ZERO;
            load_q      <= CNT_ZERO;
            hold_q      <= HOLD_ZERO;
            rst_req_x_q <= 1'b1;
            warn_q      <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_q      <= load_d;
            hold_q      <= hold_d;
            rst_req_x_q <= rst_req_x_d;
            warn_q      <= warn_d;
            seen_q      <= seen_d;
        end
    end

    assign RST_REQ_X    = rst_req_x_q;
    assign WARN         = warn_q;
    assign TIMEOUT_SEEN = seen_q;
    assign CNT_O        = cnt_q;

endmodule : rst_watchdog

// File: tb/tb_rst_watchdog.sv
// -----------------------------------------------------------------------------
// tb_rst_watchdog
// Directed self-checking bench for rst_watchdog (CNT_W=24, HOLD_CYC=4).
// Each step drives inputs, pushes the expected post-edge outputs onto a
// scoreboard queue, clocks once and pops/compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_rst_watchdog;

    localparam int unsigned CNT_W    = 24;
    localparam int unsigned HOLD_CYC = 4;
    localparam logic [7:0]  GOOD_KEY = 8'hA5;
    localparam logic [7:0]  BAD_KEY  = 8'h5A;

    logic             CLK;
    logic             RST_X;
    logic             CFG_WE;
    logic             CFG_EN;
    logic [CNT_W-1:0] CFG_TIMEOUT;
    logic             KICK;
    logic [7:0]       KICK_KEY;
    logic             CLR_FLAG;
    logic             RST_REQ_X;
    logic             WARN;
    logic             TIMEOUT_SEEN;
    logic [CNT_W-1:0] CNT_O;

    typedef struct {
        string       tag;
        logic [23:0] cnt;
        logic        warn;
        logic        req;
        logic        seen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    rst_watchdog #(
        .CNT_W    (CNT_W),
        .HOLD_CYC (HOLD_CYC),
        .KEY      (GOOD_KEY)
    ) dut (
        .CLK          (CLK),
        .RST_X        (RST_X),
        .CFG_WE       (CFG_WE),
        .CFG_EN       (CFG_EN),
        .CFG_TIMEOUT  (CFG_TIMEOUT),
        .KICK         (KICK),
        .KICK_KEY     (KICK_KEY),
        .CLR_FLAG     (CLR_FLAG),
        .RST_REQ_X    (RST_REQ_X),
        .WARN         (WARN),
        .TIMEOUT_SEEN (TIMEOUT_SEEN),
        .CNT_O        (CNT_O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input string fld,
                       input logic [23:0] obs, input logic [23:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
        end
    endtask

    // One clock: queue expectation, clock, pop and compare, drop strobes.
    task automatic cyc(input string tag, input int unsigned cnt,
                       input logic warn, input logic req, input logic seen);
        exp_t e;
        exp_t got;
        e.tag  = tag;
        e.cnt  = cnt[23:0];
        e.warn = warn;
        e.req  = req;
        e.seen = seen;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        chk(got.tag, "cnt",  CNT_O,                got.cnt);
        chk(got.tag, "warn", {23'd0, WARN},        {23'd0, got.warn});
        chk(got.tag, "req",  {23'd0, RST_REQ_X},   {23'd0, got.req});
        chk(got.tag, "seen", {23'd0, TIMEOUT_SEEN},{23'd0, got.seen});
        CFG_WE   = 1'b0;
        KICK     = 1'b0;
        CLR_FLAG = 1'b0;
    endtask

    task automatic cfg(input logic en, input int unsigned t);
        CFG_WE      = 1'b1;
        CFG_EN      = en;
        CFG_TIMEOUT = t[23:0];
    endtask

    task automatic kick(input logic [7:0] key);
        KICK     = 1'b1;
        KICK_KEY = key;
    endtask

    initial begin
        RST_X       = 1'b0;
        CFG_WE      = 1'b0;
        CFG_EN      = 1'b0;
        CFG_TIMEOUT = 24'd0;
        KICK        = 1'b0;
        KICK_KEY    = 8'h00;
        CLR_FLAG    = 1'b0;

        // Reset state.
        cyc("reset0", 0, 1'b0, 1'b1, 1'b0);
        cyc("reset1", 0, 1'b0, 1'b1, 1'b0);
        RST_X = 1'b1;
        cyc("idle", 0, 1'b0, 1'b1, 1'b0);

        // DISABLED ignores kicks and enable-with-zero.
        kick(BAD_KEY);
        cyc("dis_kick", 0, 1'b0, 1'b1, 1'b0);
        cfg(1'b1, 0);
        cyc("dis_en_t0", 0, 1'b0, 1'b1, 1'b0);
        cyc("dis_en_t0_hold", 0, 1'b0, 1'b1, 1'b0);

        // T=10 with no kicks: WARN from cnt=5, fire at edge 11 for 4 cycles.
        cfg(1'b1, 10);
        cyc("load", 10, 1'b0, 1'b1, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            cyc("count", 10 - e, ((10 - e) <= 5) ? 1'b1 : 1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < HOLD_CYC; i++) begin
            cyc("fire_to", 0, 1'b0, 1'b0, 1'b1);
        end
        cyc("rearm", 10, 1'b0, 1'b1, 1'b1);
        CLR_FLAG = 1'b1;
        cyc("clr", 9, 1'b0, 1'b1, 1'b0);

        // Valid kick every 4 cycles for 1000 cycles.
        for (int k = 0; k < 250; k++) begin
            kick(GOOD_KEY);
            cyc("kick_ok", 10, 1'b0, 1'b1, 1'b0);
            cyc("kick_run", 9, 1'b0, 1'b1, 1'b0);
            cyc("kick_run", 8, 1'b0, 1'b1, 1'b0);
            cyc("kick_run", 7, 1'b0, 1'b1, 1'b0);
        end
        kick(GOOD_KEY);
        cyc("kick_ok", 10, 1'b0, 1'b1, 1'b0);
        cyc("pre_bad", 9, 1'b0, 1'b1, 1'b0);
        cyc("pre_bad", 8, 1'b0, 1'b1, 1'b0);

        // Bad key at cnt=8, then a disable write while firing is ignored.
        kick(BAD_KEY);
        cyc("bad_key", 8, 1'b0, 1'b0, 1'b1);
        cfg(1'b0, 10);
        cyc("fire_dis", 8, 1'b0, 1'b0, 1'b1);
        kick(GOOD_KEY);
        cyc("fire_kick", 8, 1'b0, 1'b0, 1'b1);
        cyc("fire_last", 8, 1'b0, 1'b0, 1'b1);
        cyc("fire_done", 10, 1'b0, 1'b1, 1'b1);

        // Valid kick exactly at cnt==0 rescues.
        CLR_FLAG = 1'b1;
        cyc("clr2", 9, 1'b0, 1'b1, 1'b0);
        for (int c = 8; c >= 0; c--) begin
            cyc("down", c, (c <= 5) ? 1'b1 : 1'b0, 1'b1, 1'b0);
        end
        kick(GOOD_KEY);
        cyc("kick_at0", 10, 1'b0, 1'b1, 1'b0);
        cyc("after_kick0", 9, 1'b0, 1'b1, 1'b0);

        // Disable write during WARN.
        for (int c = 8; c >= 5; c--) begin
            cyc("to_warn", c, (c <= 5) ? 1'b1 : 1'b0, 1'b1, 1'b0);
        end
        cfg(1'b0, 10);
        cyc("dis_warn", 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc("dis_stay", 0, 1'b0, 1'b1, 1'b0);
        end

        // Re-enable from WARN reloads and drops WARN.
        cfg(1'b1, 4);
        cyc("load4", 4, 1'b0, 1'b1, 1'b0);
        cyc("d3", 3, 1'b0, 1'b1, 1'b0);
        cyc("d2", 2, 1'b1, 1'b1, 1'b0);
        cfg(1'b1, 3);
        cyc("reload3", 3, 1'b0, 1'b1, 1'b0);
        cyc("r2", 2, 1'b0, 1'b1, 1'b0);
        cyc("r1", 1, 1'b1, 1'b1, 1'b0);
        cyc("r0", 0, 1'b1, 1'b1, 1'b0);

        // CLR_FLAG on the fire-entry cycle loses; reset on 2nd fire cycle.
        CLR_FLAG = 1'b1;
        cyc("fire_clr", 0, 1'b0, 1'b0, 1'b1);
        cyc("fire_2nd", 0, 1'b0, 1'b0, 1'b1);
        RST_X = 1'b0;
        cyc("mid_fire_rst", 0, 1'b0, 1'b1, 1'b0);
        RST_X    = 1'b1;
        CLR_FLAG = 1'b1;
        cyc("post_rst_clr", 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc("post_rst_idle", 0, 1'b0, 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rst_watchdog
